mux_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32-bit 4:1 datapath mux, and the single resource behind it (e.g. a memory port), among four requesters.
- Produces the registered 2-bit mux select plus a one-hot grant.
- Holds each grant until the resource signals completion, the requester withdraws, or a watchdog timeout fires.
- Sits between the CPU-side requesters (fetch, load/store, debug, DMA) and the shared mux/resource.

---
 rtl/mux_port_arbiter_if.sv | 35 +++
 rtl/mux_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mux_port_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mux_port_arbiter_if.sv
// mux_port_arbiter_if
//   Bundles the requester/resource handshake of the shared mux port.
//   req         : per-requester request, held for the whole transaction
//   done        : single-cycle completion pulse from the shared resource
//   gnt         : one-hot grant (zero when idle)
//   sel         : mux select, index of the current/last owner
//   gnt_valid   : high while a grant is active
//   timeout_err : one-cycle pulse when the watchdog revokes a grant
//   master modport: requester/resource side; slave modport: the arbiter.
interface mux_port_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       gnt_valid;
  logic       timeout_err;

  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  gnt_valid,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output gnt_valid,
    output timeout_err
  );
endinterface

// File: rtl/mux_port_arbiter.sv
// mux_port_arbiter
//   Round-robin arbiter sharing one 4:1 datapath mux (and the resource behind
//   it) among four requesters. A grant is held until done, until the owner
//   withdraws its request, or until the hold watchdog expires. Every release
//   passes through IDLE, giving a one-cycle bubble between grants.
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset
//     bus : mux_port_arbiter_if.slave (req, done in; gnt, sel, gnt_valid,
//           timeout_err out, all outputs registered)
//   Parameters:
//     TIMEOUT : max hold cycles without done, 0 disables the watchdog
//     CW      : hold counter width, TIMEOUT must fit in CW bits
module mux_port_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_port_arbiter_if.slave     bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Last hold count before the watchdog fires; unused when TIMEOUT == 0.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? {CW{1'b0}} : CW'(TIMEOUT - 1);

  state_t        state_r;
  logic [1:0]    ptr_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    gnt_r;
  logic [1:0]    sel_r;
  logic          gnt_valid_r;
  logic          timeout_err_r;

  logic [1:0]    pick_s;
  logic          found_s;
  logic [1:0]    cand_s;
  logic          wd_hit_s;
  logic          abort_s;
  logic          release_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // Round-robin pick: first asserted request scanning ptr, ptr+1, ... mod 4.
  always_comb begin
    pick_s  = 2'd0;
    found_s = 1'b0;
    cand_s  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand_s  = ptr_r + 2'(i);
      pick_s  = (!found_s && bus.req[cand_s]) ? cand_s : pick_s;
      found_s = found_s | bus.req[cand_s];
    end
  end

  // Release conditions for the current owner (sel_r holds the owner index).
  always_comb begin
    abort_s   = ~bus.req[sel_r];
    wd_hit_s  = (TIMEOUT != 0) && (cnt_r == TO_LAST);
    release_s = bus.done | abort_s | wd_hit_s;
  end

  // Arbitration FSM with registered outputs, pointer and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      ptr_r         <= 2'd0;
      cnt_r         <= {CW{1'b0}};
      gnt_r         <= 4'b0000;
      sel_r         <= 2'd0;
      gnt_valid_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          timeout_err_r <= 1'b0;
          if (found_s) begin
            gnt_r       <= onehot(pick_s);
            sel_r       <= pick_s;
            gnt_valid_r <= 1'b1;
            cnt_r       <= {CW{1'b0}};
            state_r     <= OWN;
          end
        end
        OWN: begin
          if (release_s) begin
            // Watchdog only flags when neither done nor a withdrawal caused the release.
            timeout_err_r <= ~bus.done & ~abort_s & wd_hit_s;
            gnt_r         <= 4'b0000;
            gnt_valid_r   <= 1'b0;
            ptr_r         <= sel_r + 2'd1;
            state_r       <= IDLE;
          end else begin
            timeout_err_r <= 1'b0;
            if (cnt_r != {CW{1'b1}}) begin
              cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_r       <= IDLE;
          gnt_r         <= 4'b0000;
          gnt_valid_r   <= 1'b0;
          timeout_err_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.sel         = sel_r;
  assign bus.gnt_valid   = gnt_valid_r;
  assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Directed self-checking bench for mux_port_arbiter (TIMEOUT=5).
module tb_mux_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mux_port_arbiter_if bus_if ();

  mux_port_arbiter #(.TIMEOUT(5), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic te);
    chk({tag, ".gnt"}, 32'(bus_if.gnt), 32'(g));
    chk({tag, ".sel"}, 32'(bus_if.sel), 32'(s));
    chk({tag, ".gv"},  32'(bus_if.gnt_valid), 32'(g != 4'b0000));
    chk({tag, ".te"},  32'(bus_if.timeout_err), 32'(te));
  endtask

  initial begin
    bus_if.req  = 4'b0000;
    bus_if.done = 1'b0;
    step(); step();
    chk_out("reset", 4'b0000, 2'd0, 1'b0);

    // Single requester 2, done three cycles into the grant.
    rst = 1'b0;
    bus_if.req = 4'b0100;
    step();
    chk_out("t1_grant", 4'b0100, 2'd2, 1'b0);
    step(); step();
    bus_if.done = 1'b1;
    step();
    bus_if.done = 1'b0;
    bus_if.req  = 4'b0000;
    chk_out("t1_release", 4'b0000, 2'd2, 1'b0);
    bus_if.done = 1'b1;
    step();
    bus_if.done = 1'b0;
    chk_out("t1_done_idle", 4'b0000, 2'd2, 1'b0);

    // All four requesting: rotation 0,1,2,3,0 with a one-cycle bubble.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_if.req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("t2_grant%0d", k), 4'b0001 << (k % 4), 2'(k % 4), 1'b0);
      step();
      bus_if.done = 1'b1;
      step();
      bus_if.done = 1'b0;
      if (k == 4) bus_if.req = 4'b0000;
      chk_out($sformatf("t2_bubble%0d", k), 4'b0000, 2'(k % 4), 1'b0);
      step();
    end
    chk_out("t2_idle", 4'b0000, 2'd0, 1'b0);

    // Pointer wrap: owner 3 releases while 0 and 3 request, 0 must win.
    bus_if.req = 4'b1000;
    step();
    chk_out("t3_own3", 4'b1000, 2'd3, 1'b0);
    bus_if.req  = 4'b1001;
    bus_if.done = 1'b1;
    step();
    bus_if.done = 1'b0;
    chk_out("t3_rel", 4'b0000, 2'd3, 1'b0);
    step();
    chk_out("t3_wrap", 4'b0001, 2'd0, 1'b0);
    bus_if.req  = 4'b0000;
    bus_if.done = 1'b1;
    step();
    bus_if.done = 1'b0;
    chk_out("t3_idle", 4'b0000, 2'd0, 1'b0);

    // Watchdog: requester 1 holds with no done for 5 cycles.
    bus_if.req = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out($sformatf("t4_hold%0d", k), 4'b0010, 2'd1, 1'b0);
    end
    step();
    chk_out("t4_timeout", 4'b0000, 2'd1, 1'b1);
    bus_if.req = 4'b0110;
    step();
    chk_out("t4_next", 4'b0100, 2'd2, 1'b0);

    // done coincides with the watchdog cycle: normal release.
    step(); step(); step(); step();
    chk_out("t5_hold", 4'b0100, 2'd2, 1'b0);
    bus_if.done = 1'b1;
    step();
    bus_if.done = 1'b0;
    chk_out("t5_release", 4'b0000, 2'd2, 1'b0);
    step();
    chk_out("t5_next", 4'b0010, 2'd1, 1'b0);

    // Owner 1 withdraws: abort release, pointer moves to 2.
    bus_if.req = 4'b0101;
    step();
    chk_out("t6_abort", 4'b0000, 2'd1, 1'b0);
    step();
    chk_out("t6_next", 4'b0100, 2'd2, 1'b0);

    // Reset during a grant, then done while idle.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_if.req = 4'b0000;
    chk_out("t7_rst", 4'b0000, 2'd0, 1'b0);
    bus_if.done = 1'b1;
    step();
    bus_if.done = 1'b0;
    chk_out("t7_done_idle", 4'b0000, 2'd0, 1'b0);
    bus_if.req = 4'b1010;
    step();
    chk_out("t7_ptr0", 4'b0010, 2'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
